// File: rtl/sha3_stream_ctrl.sv
// Byte-stream front end for a SHA3-256 permutation core: packs bytes into rate-sized
// blocks, applies SHA-3 padding, hands blocks to the core and captures the final digest.
module sha3_stream_ctrl #(
    parameter int RATE_BYTES = 136
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    input  logic                      s_zero,
    output logic                      s_ready,
    output logic [RATE_BYTES*8-1:0]   blk_data,
    output logic                      blk_start,
    output logic                      blk_is_last,
    input  logic                      core_ready,
    input  logic [255:0]              core_hash,
    output logic [255:0]              digest,
    output logic                      digest_valid,
    input  logic                      digest_ack
);

    localparam int         W        = RATE_BYTES * 8;
    localparam logic [7:0] LAST_IDX = 8'(RATE_BYTES - 1);

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        PAD     = 3'd1,
        ISSUE   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     pad_idx_q, pad_idx_d;
    logic [W-1:0]   buf_q, buf_d;
    logic           last_q, last_d;
    logic           pad_pend_q, pad_pend_d;
    logic [255:0]   digest_q, digest_d;
    logic           digest_valid_q, digest_valid_d;
    logic           blk_start_q, blk_start_d;
    logic           blk_is_last_q, blk_is_last_d;
    logic           s_ready_q, s_ready_d;
    logic           accept_s;
    logic           zero_beat_s;

    // Byte 0 sits in the most significant byte lane of the block.
    function automatic logic [W-1:0] put_byte(input logic [W-1:0] blk, input logic [7:0] idx,
                                              input logic [7:0] val, input logic merge);
        logic [W-1:0] res;
        int           base;
        res  = blk;
        base = (RATE_BYTES - 1 - int'(idx)) * 8;
        if (merge) begin
            res[base +: 8] = blk[base +: 8] | val;
        end else begin
            res[base +: 8] = val;
        end
        return res;
    endfunction

    assign accept_s    = s_valid & s_ready_q & (state_q == FILL);
    assign zero_beat_s = s_zero & s_last;

    // Next-state and datapath update for the block/padding/handshake sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pad_idx_d      = pad_idx_q;
        buf_d          = buf_q;
        last_d         = last_q;
        pad_pend_d     = pad_pend_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        blk_start_d    = 1'b0;
        blk_is_last_d  = blk_is_last_q;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    if (!zero_beat_s) begin
                        buf_d = put_byte(buf_q, cnt_q, s_data, 1'b0);
                    end else begin
                        buf_d = buf_q;
                    end
                    if (zero_beat_s) begin
                        pad_idx_d = cnt_q;
                        state_d   = PAD;
                    end else if (cnt_q == LAST_IDX) begin
                        // A last byte that fills the block still needs a separate padding block.
                        cnt_d      = 8'd0;
                        last_d     = 1'b0;
                        pad_pend_d = s_last;
                        state_d    = ISSUE;
                    end else if (s_last) begin
                        pad_idx_d = cnt_q + 8'd1;
                        state_d   = PAD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            PAD: begin
                buf_d      = put_byte(put_byte(buf_q, pad_idx_q, 8'h06, 1'b1), LAST_IDX, 8'h80, 1'b1);
                last_d     = 1'b1;
                pad_pend_d = 1'b0;
                cnt_d      = 8'd0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (core_ready) begin
                    blk_start_d   = 1'b1;
                    blk_is_last_d = last_q;
                    state_d       = WAIT_LO;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_LO: begin
                if (!core_ready) begin
                    state_d = WAIT_HI;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_HI: begin
                if (core_ready) begin
                    if (last_q) begin
                        digest_d       = core_hash;
                        digest_valid_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        buf_d = '0;
                        if (pad_pend_q) begin
                            pad_idx_d = 8'd0;
                            state_d   = PAD;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (digest_ack) begin
                    digest_valid_d = 1'b0;
                    buf_d          = '0;
                    cnt_d          = 8'd0;
                    state_d        = FILL;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        s_ready_d = (state_d == FILL);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FILL;
            cnt_q          <= 8'd0;
            pad_idx_q      <= 8'd0;
            buf_q          <= '0;
            last_q         <= 1'b0;
            pad_pend_q     <= 1'b0;
            digest_q       <= 256'd0;
            digest_valid_q <= 1'b0;
            blk_start_q    <= 1'b0;
            blk_is_last_q  <= 1'b0;
            s_ready_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pad_idx_q      <= pad_idx_d;
            buf_q          <= buf_d;
            last_q         <= last_d;
            pad_pend_q     <= pad_pend_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            blk_start_q    <= blk_start_d;
            blk_is_last_q  <= blk_is_last_d;
            s_ready_q      <= s_ready_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign blk_data     = buf_q;
    assign blk_start    = blk_start_q;
    assign blk_is_last  = blk_is_last_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha3_stream_ctrl.sv
// Scoreboard bench for sha3_stream_ctrl: expected blocks and digests are queued by the
// stimulus, and a negedge monitor compares them as the DUT presents them.
module tb_sha3_stream_ctrl;

    localparam logic [255:0] H_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    localparam logic [255:0] H_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
    localparam logic [255:0] H_FOX   = 256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;
    localparam logic [255:0] H_135   = {8{32'h13513513}};
    localparam logic [255:0] H_136   = {8{32'h13613613}};
    localparam logic [255:0] H_200   = {8{32'h20020020}};

    typedef struct packed {
        logic          last;
        logic [1087:0] data;
    } blk_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] s_data;
    logic s_valid, s_last, s_zero, s_ready;
    logic [1087:0] blk_data;
    logic blk_start, blk_is_last;
    logic core_ready;
    logic [255:0] core_hash;
    logic [255:0] digest;
    logic digest_valid, digest_ack;

    blk_t          exp_blk[$];
    logic [255:0]  exp_dig[$];
    logic [7:0]    msg [0:255];
    int            msg_len = 0;
    int            checks = 0;
    int            errors = 0;
    int            blk_cnt = 0;
    int            busy = 6;
    logic          hold_off = 1'b0;
    logic [255:0]  cur_hash = 256'd0;
    logic [1087:0] obs_blk = '0;

    always #5 clk = ~clk;

    sha3_stream_ctrl #(.RATE_BYTES(136)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_zero(s_zero), .s_ready(s_ready), .blk_data(blk_data), .blk_start(blk_start),
        .blk_is_last(blk_is_last), .core_ready(core_ready), .core_hash(core_hash),
        .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1087:0] act, input logic [1087:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int j = 135; j >= 0; j--) begin
                if (act[1087-8*j -: 8] !== exp[1087-8*j -: 8]) bad = j;
            end
            $display("FAIL %s: byte %0d got %h expected %h at %0t", name, bad,
                     act[1087-8*bad -: 8], exp[1087-8*bad -: 8], $time);
        end
    endtask

    // Reference padding: block k carries bytes 136k.., final block gets 0x06 after the data and 0x80 at byte 135.
    task automatic expect_msg(input logic [255:0] h);
        int   nblk, r, idx;
        blk_t e;
        nblk = msg_len / 136 + 1;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            e.last = (b == nblk - 1);
            for (int j = 0; j < 136; j++) begin
                idx = b * 136 + j;
                if (idx < msg_len) e.data[1087-8*j -: 8] = msg[idx];
            end
            if (e.last) begin
                r = msg_len - b * 136;
                e.data[1087-8*r -: 8] = e.data[1087-8*r -: 8] | 8'h06;
                e.data[7:0] = e.data[7:0] | 8'h80;
            end
            exp_blk.push_back(e);
        end
        exp_dig.push_back(h);
        cur_hash = h;
    endtask

    task automatic load_str(input string s);
        msg_len = s.len();
        for (int i = 0; i < msg_len; i++) msg[i] = s[i];
    endtask

    task automatic load_pat(input int n);
        msg_len = n;
        for (int i = 0; i < n; i++) msg[i] = 8'(i * 7 + 3);
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic z);
        logic acc;
        int   t;
        s_valid = 1'b1; s_data = d; s_last = l; s_zero = z;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 5000) begin
            acc = s_ready;
            @(posedge clk); #1;
            t++;
        end
        chk1("beat_accept", acc, 1'b1);
        s_valid = 1'b0; s_last = 1'b0; s_zero = 1'b0;
    endtask

    task automatic send_msg(input int n_send, input bit gaps, input bit zero_mid, input bit zero_tail);
        for (int i = 0; i < n_send; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drive_beat(msg[i], (i == msg_len - 1) && !zero_tail, zero_mid && (i != msg_len - 1));
        end
        if (zero_tail) drive_beat(8'h00, 1'b1, 1'b1);
    endtask

    task automatic finish_msg(input int ack_delay);
        int t;
        t = 0;
        while (!digest_valid && t < 3000) begin @(posedge clk); #1; t++; end
        chk1("digest_valid_seen", digest_valid, 1'b1);
        for (int k = 0; k < ack_delay; k++) begin
            chk1("s_ready_in_done", s_ready, 1'b0);
            chk256("digest_hold", digest, cur_hash);
            @(posedge clk); #1;
        end
        digest_ack = 1'b1;
        @(posedge clk); #1;
        digest_ack = 1'b0;
        chk1("dv_after_ack", digest_valid, 1'b0);
        chk1("s_ready_after_ack", s_ready, 1'b1);
        chk_int("blk_queue_empty", exp_blk.size(), 0);
        chk_int("dig_queue_empty", exp_dig.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_s_ready"}, s_ready, 1'b0);
        chk1({tag, "_blk_start"}, blk_start, 1'b0);
        chk1({tag, "_blk_is_last"}, blk_is_last, 1'b0);
        chk1({tag, "_digest_valid"}, digest_valid, 1'b0);
        chk256({tag, "_digest"}, digest, 256'd0);
        chk_blk({tag, "_blk_data"}, blk_data, '0);
    endtask

    // Core model: busy for a few cycles after each start, digest only valid after a final block.
    initial begin
        logic lastb;
        core_ready = 1'b1;
        core_hash  = 256'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                core_ready = 1'b1;
            end else if (blk_start) begin
                lastb = blk_is_last;
                core_ready = 1'b0;
                repeat (busy) begin @(posedge clk); #1; end
                core_ready = 1'b1;
                core_hash = lastb ? cur_hash : ~cur_hash;
            end else begin
                core_ready = !hold_off;
            end
        end
    end

    // Monitor: score each block start and each digest, and watch block stability while the core works.
    initial begin
        blk_t          e;
        logic          win, seen_low, dv_prev;
        logic [1087:0] held;
        win = 1'b0; seen_low = 1'b0; dv_prev = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win = 1'b0; seen_low = 1'b0; dv_prev = 1'b0;
            end else begin
                if (win) begin
                    if (core_ready && seen_low) begin
                        win = 1'b0;
                    end else begin
                        if (!core_ready) seen_low = 1'b1;
                        chk_blk("blk_stable", blk_data, held);
                    end
                end
                if (blk_start) begin
                    obs_blk = blk_data;
                    held = blk_data;
                    win = 1'b1;
                    seen_low = 1'b0;
                    blk_cnt++;
                    if (exp_blk.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL blk_extra: got unexpected blk_start expected none at %0t", $time);
                    end else begin
                        e = exp_blk.pop_front();
                        chk1("blk_is_last", blk_is_last, e.last);
                        chk_blk("blk_data", blk_data, e.data);
                    end
                end
                if (digest_valid && !dv_prev) begin
                    if (exp_dig.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dig_extra: got %h expected none at %0t", digest, $time);
                    end else begin
                        chk256("digest", digest, exp_dig.pop_front());
                    end
                end
                dv_prev = digest_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            c0, t;
        logic [1087:0] snap;
        rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_zero = 1'b0; digest_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        chk1("s_ready_before_edge", s_ready, 1'b0);
        @(posedge clk); #1;
        chk1("s_ready_first_edge", s_ready, 1'b1);

        // Empty message as a single zero beat.
        load_pat(0);
        expect_msg(H_EMPTY);
        send_msg(0, 0, 0, 1);
        finish_msg(2);
        chk256("empty_byte0", {248'd0, obs_blk[1087 -: 8]}, {248'd0, 8'h06});
        chk256("empty_byte135", {248'd0, obs_blk[7:0]}, {248'd0, 8'h80});

        load_str("abc");
        expect_msg(H_ABC);
        send_msg(3, 0, 0, 0);
        finish_msg(2);
        chk256("abc_head", {224'd0, obs_blk[1087 -: 32]}, {224'd0, 32'h61626306});

        load_pat(135);
        c0 = blk_cnt;
        expect_msg(H_135);
        send_msg(135, 0, 0, 0);
        finish_msg(1);
        chk_int("blocks_135", blk_cnt - c0, 1);
        chk256("b135_byte135", {248'd0, obs_blk[7:0]}, {248'd0, 8'h86});

        load_pat(136);
        c0 = blk_cnt;
        expect_msg(H_136);
        send_msg(136, 0, 0, 0);
        finish_msg(1);
        chk_int("blocks_136", blk_cnt - c0, 2);
        chk256("b136_pad_byte0", {248'd0, obs_blk[1087 -: 8]}, {248'd0, 8'h06});
        chk256("b136_pad_byte135", {248'd0, obs_blk[7:0]}, {248'd0, 8'h80});

        // Gaps in s_valid, s_zero on non-last beats, slow acknowledge.
        load_str("The quick brown fox jumps over the lazy dog");
        expect_msg(H_FOX);
        send_msg(msg_len, 1, 1, 0);
        finish_msg(20);

        // Reset while the core works on the first block of a 200-byte message.
        load_pat(200);
        expect_msg(H_200);
        c0 = blk_cnt;
        send_msg(136, 0, 0, 0);
        t = 0;
        while (blk_cnt == c0 && t < 200) begin @(posedge clk); #1; t++; end
        chk_int("b200_first_block", blk_cnt - c0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_blk.delete();
        exp_dig.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_str("abc");
        expect_msg(H_ABC);
        send_msg(3, 0, 0, 0);
        finish_msg(2);

        // Core held busy: no start while blocked, buffer frozen, trailing zero beat.
        hold_off = 1'b1;
        @(posedge clk); #1;
        load_str("abc");
        expect_msg(H_ABC);
        c0 = blk_cnt;
        send_msg(3, 0, 0, 1);
        @(posedge clk); #1;
        snap = blk_data;
        chk256("hold_head", {224'd0, snap[1087 -: 32]}, {224'd0, 32'h61626306});
        chk256("hold_byte135", {248'd0, snap[7:0]}, {248'd0, 8'h80});
        for (int k = 0; k < 30; k++) begin
            chk1("hold_no_start", blk_start, 1'b0);
            chk_blk("hold_blk_stable", blk_data, snap);
            @(posedge clk); #1;
        end
        hold_off = 1'b0;
        finish_msg(2);
        chk_int("hold_one_block", blk_cnt - c0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
